// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns a load/store into a request/ack
// handshake, stalls the CPU until writeback and flags sticky timeouts.
module dm_access_ctrl #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mem_op,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             rd_en,
    output logic             dm_req,
    output logic             dm_we,
    output logic [WIDTH-1:0] dm_addr,
    output logic [WIDTH-1:0] dm_wdata,
    input  logic             dm_ack,
    input  logic [WIDTH-1:0] dm_rdata,
    output logic             result_src,
    output logic [WIDTH-1:0] result,
    output logic             reg_we,
    output logic             stall,
    output logic             err
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] cap_addr, cap_wdata, cap_alu, cap_rdata;
    logic             cap_rd_en, cap_load, tmo;
    logic [CW-1:0]    cnt;
    logic             mem_go, tmo_hit;

    assign mem_go  = (state == IDLE) && (mem_op == 2'b01 || mem_op == 2'b10);
    // An ack on the last allowed cycle wins over the timeout.
    assign tmo_hit = (state == ACCESS) && !dm_ack && (cnt == CW'(TIMEOUT_CYC - 1));

    assign dm_addr  = cap_addr;
    assign dm_wdata = cap_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        stall      = 1'b0;
        result_src = 1'b0;
        result     = alu_result;
        reg_we     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_go) begin
                    stall     = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    reg_we = rd_en;
                end
            end
            ACCESS: begin
                dm_req = 1'b1;
                dm_we  = !cap_load;
                stall  = 1'b1;
                result = cap_alu;
                if (dm_ack || tmo_hit) state_nxt = WB;
            end
            WB: begin
                state_nxt = IDLE;
                if (tmo) begin
                    result_src = 1'b1;
                    result     = '0;
                end else if (cap_load) begin
                    result_src = 1'b1;
                    result     = cap_rdata;
                    reg_we     = cap_rd_en;
                end else begin
                    result = cap_alu;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_alu   <= '0;
            cap_rdata <= '0;
            cap_rd_en <= 1'b0;
            cap_load  <= 1'b0;
            tmo       <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_go) begin
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        cap_alu   <= alu_result;
                        cap_rd_en <= rd_en;
                        cap_load  <= (mem_op == 2'b01);
                        tmo       <= 1'b0;
                        cnt       <= '0;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        if (cap_load) cap_rdata <= dm_rdata;
                    end else if (tmo_hit) begin
                        tmo <= 1'b1;
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of stall/request/writeback.
module tb_dm_access_ctrl;
    localparam int W = 32;
    localparam int T = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mem_op;
    logic [W-1:0]  addr, wdata, alu_result, dm_rdata, dm_addr, dm_wdata, result;
    logic          rd_en, dm_req, dm_we, dm_ack, result_src, reg_we, stall, err;

    int checks = 0;
    int errors = 0;
    logic err_model = 1'b0;

    dm_access_ctrl #(.WIDTH(W), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .alu_result(alu_result), .rd_en(rd_en), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .result_src(result_src), .result(result), .reg_we(reg_we), .stall(stall),
        .err(err)
    );

    always #5 clk = ~clk;

    // One non-memory cycle in IDLE; outputs must follow inputs combinationally.
    task automatic do_pass(input logic [1:0] op, input logic [W-1:0] alu, input logic rd, input string nm);
        @(negedge clk);
        mem_op = op; alu_result = alu; rd_en = rd;
        addr = $urandom; wdata = $urandom; dm_ack = 1'($urandom); dm_rdata = $urandom;
        #1;
        checks++;
        if ({result, result_src, reg_we, stall, dm_req, err} !== {alu, 1'b0, rd, 1'b0, 1'b0, err_model}) begin
            errors++;
            $display("FAIL %s: res=%h src=%b we=%b stall=%b req=%b err=%b, want res=%h src=0 we=%b stall=0 req=0 err=%b",
                     nm, result, result_src, reg_we, stall, dm_req, err, alu, rd, err_model);
        end
    endtask

    // Full memory transaction; ack_at = ACCESS cycle of the ack (0 or >T = never).
    task automatic do_mem(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] wd,
                          input logic [W-1:0] alu, input logic rd, input int ack_at,
                          input logic [W-1:0] rdv, input string nm);
        logic is_load, timed_out;
        int   n;
        logic [W-1:0] exp_res;
        is_load   = (op == 2'b01);
        timed_out = (ack_at < 1) || (ack_at > T);
        n         = timed_out ? T : ack_at;
        @(negedge clk);
        mem_op = op; addr = a; wdata = wd; alu_result = alu; rd_en = rd;
        dm_ack = 1'($urandom); dm_rdata = $urandom;
        #1;
        checks++;
        if ({stall, reg_we, dm_req} !== 3'b100) begin
            errors++;
            $display("FAIL %s req-cycle: stall/we/req=%b want 100", nm, {stall, reg_we, dm_req});
        end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            mem_op = 2'($urandom); addr = $urandom; wdata = $urandom;
            dm_ack = (i == ack_at);
            dm_rdata = (i == ack_at) ? rdv : $urandom;
            #1;
            checks++;
            if ({dm_req, dm_we, stall, reg_we, dm_addr, dm_wdata} !== {1'b1, !is_load, 1'b1, 1'b0, a, wd}) begin
                errors++;
                $display("FAIL %s access%0d: req=%b we=%b stall=%b rwe=%b addr=%h wd=%h want 1 %b 1 0 %h %h",
                         nm, i, dm_req, dm_we, stall, reg_we, dm_addr, dm_wdata, !is_load, a, wd);
            end
        end
        if (timed_out) err_model = 1'b1;
        exp_res = timed_out ? '0 : (is_load ? rdv : alu);
        @(negedge clk);
        mem_op = 2'b00; rd_en = 1'($urandom); dm_ack = 1'($urandom); dm_rdata = $urandom;
        #1;
        checks++;
        if ({result_src, result, reg_we, stall, dm_req, err} !==
            {timed_out | is_load, exp_res, !timed_out & is_load & rd, 1'b0, 1'b0, err_model}) begin
            errors++;
            $display("FAIL %s wb: src=%b res=%h we=%b stall=%b req=%b err=%b, want src=%b res=%h we=%b stall=0 req=0 err=%b",
                     nm, result_src, result, reg_we, stall, dm_req, err,
                     timed_out | is_load, exp_res, !timed_out & is_load & rd, err_model);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_op = 2'b00; addr = '0; wdata = '0; alu_result = 32'h55AA;
        rd_en = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
        #12;
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, err, result, reg_we, stall} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h55AA, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wd=%h err=%b res=%h rwe=%b stall=%b",
                     dm_req, dm_we, dm_addr, dm_wdata, err, result, reg_we, stall);
        end
        mem_op = 2'b10; #1;
        checks++;
        if ({stall, reg_we, dm_req} !== 3'b100) begin
            errors++;
            $display("FAIL reset_memop: stall/we/req=%b want 100", {stall, reg_we, dm_req});
        end
        @(negedge clk);
        checks++;
        if (dm_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: dm_req=%b want 0", dm_req);
        end
        mem_op = 2'b00; rst = 1'b0;
    endtask

    task automatic test_passthrough();
        do_pass(2'b00, 32'h0000_1234, 1'b1, "pass_basic");
        do_pass(2'b11, 32'hCAFE_0001, 1'b1, "pass_reserved");
        for (int i = 0; i < 6; i++)
            do_pass(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, $urandom, 1'($urandom), "pass_rand");
    endtask

    task automatic test_load();  do_mem(2'b01, 32'h40, 32'h0, 32'h7, 1'b1, 3, 32'hDEADBEEF, "load_ack3"); endtask
    task automatic test_store(); do_mem(2'b10, 32'h80, 32'hA5A5A5A5, 32'h9, 1'b1, 1, 32'h1111, "store_ack1"); endtask

    task automatic test_timeout();
        do_mem(2'b01, 32'h100, 32'h0, 32'h3, 1'b1, 0, 32'h0, "timeout");
        do_pass(2'b00, 32'h77, 1'b1, "timeout_sticky");
        do_mem(2'b01, 32'h104, 32'h0, 32'h4, 1'b1, 1, 32'h12345678, "after_timeout");
    endtask

    task automatic test_ack_at_limit();
        do_mem(2'b01, 32'h200, 32'h0, 32'h5, 1'b1, T, 32'hFEEDF00D, "ack_at_limit");
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        mem_op = 2'b01; addr = 32'h300; rd_en = 1'b1; dm_ack = 1'b0;
        @(negedge clk);
        mem_op = 2'b00; rd_en = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (dm_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: dm_req=%b want 1", dm_req);
        end
        rst = 1'b1; #1;
        err_model = 1'b0;
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, err, stall, reg_we} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: req=%b we=%b addr=%h wd=%h err=%b stall=%b rwe=%b want all 0",
                     dm_req, dm_we, dm_addr, dm_wdata, err, stall, reg_we);
        end
        @(negedge clk);
        rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({reg_we, dm_req, result_src, stall} !== 4'b0000) begin
                errors++;
                $display("FAIL stray_ack%0d: we/req/src/stall=%b want 0000", i, {reg_we, dm_req, result_src, stall});
            end
            @(negedge clk);
            dm_ack = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_pass(2'($urandom_range(0, 1) * 3), $urandom, 1'($urandom), "b2b_pass");
            else
                do_mem(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, $urandom, $urandom, $urandom,
                       1'($urandom), $urandom_range(0, T + 2), $urandom, "b2b_mem");
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: width of the address, data and result paths.
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum ACCESS cycles allowed without dm_ack; legal range 1..255.
REQ-003 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_op  in  2  operation: 00 none, 01 load, 10 store, 11 reserved (treated as none).
- addr  in  WIDTH  memory address (ALU output).
- wdata  in  WIDTH  store data.
- alu_result  in  WIDTH  non-memory result.
- rd_en  in  1  instruction writes the register file.
- dm_req  out  1  data-memory request.
- dm_we  out  1  1 = store, 0 = load.
- dm_addr  out  WIDTH  registered request address.
- dm_wdata  out  WIDTH  registered store data.
- dm_ack  in  1  memory completion, one-cycle pulse.
- dm_rdata  in  WIDTH  load data, valid when dm_ack=1.
- result_src  out  1  1 = memory data selected, 0 = ALU result selected.
- result  out  WIDTH  writeback value.
- reg_we  out  1  register-file write enable.
- stall  out  1  holds the CPU PC and instruction.
- err  out  1  sticky timeout flag.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS, WB.
REQ-005 IDLE with mem_op none or 11:
- stall=0, result_src=0, result=alu_result, reg_we=rd_en.
- These outputs are combinational pass-through with zero latency.
REQ-006 IDLE with mem_op 01 or 10:
- stall=1, reg_we=0.
- On the clock edge, capture addr, wdata, alu_result, rd_en and is_load, then go to ACCESS.
REQ-007 ACCESS:
- dm_req=1, stall=1, reg_we=0.
- dm_we, dm_addr and dm_wdata are driven from captured registers and stay stable until the state is left.
REQ-008 ACCESS with dm_ack=1:
- If is_load, capture dm_rdata.
- Go to WB.
REQ-009 ACCESS timeout:
- A cycle counter clears on entry to ACCESS and increments on each ACCESS cycle.
- If the counter equals TIMEOUT_CYC-1 and dm_ack=0, set err and go to WB with a timeout flag.
REQ-010 dm_ack in the same cycle as the timeout condition SHALL count as success: no err, normal WB.
REQ-011 WB lasts exactly one cycle with stall=0, then returns to IDLE.
- Completed load: result_src=1, result=captured rdata, reg_we=captured rd_en.
- Completed store: result_src=0, result=captured alu_result, reg_we=0.
- Timed-out access: result_src=1, result=0, reg_we=0.
REQ-012 Inputs mem_op, addr and wdata SHALL be ignored in ACCESS and WB; dm_ack SHALL be ignored in IDLE and WB.
REQ-013 Latency: for an ack on the k-th ACCESS cycle, stall is high for k+1 cycles and WB occurs in cycle k+1 after the request cycle.
REQ-014 The counter SHALL be at least ceil(log2(TIMEOUT_CYC+1)) bits wide and SHALL never wrap.
REQ-015 Back-to-back memory ops SHALL be handled with no lost or duplicated request: WB -> IDLE -> request the next op.
REQ-016 err SHALL stay at 1 until rst and SHALL NOT block later operations.

Reset
REQ-017 Asserting rst at any time, including mid-ACCESS, SHALL immediately force the following without waiting for clk:
- State IDLE.
- dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0.
- Captured registers 0, counter 0, err=0.
REQ-018 During reset the remaining outputs SHALL follow the IDLE rules (REQ-005, REQ-006) given the current inputs.
REQ-019 A pending memory ack that arrives after reset SHALL be ignored.

Verification
REQ-020 Pass-through: mem_op=00, alu_result=0x0000_1234, rd_en=1 -> same cycle result=0x1234, result_src=0, reg_we=1, stall=0, dm_req=0.
REQ-021 Load with ack on 3rd ACCESS cycle: addr=0x40, dm_rdata=0xDEADBEEF, rd_en=1 ->
- dm_req high 3 cycles with dm_addr=0x40, dm_we=0.
- stall high 4 cycles.
- WB cycle: result=0xDEADBEEF, result_src=1, reg_we=1.
REQ-022 Store with ack on 1st ACCESS cycle: addr=0x80, wdata=0xA5A5A5A5 ->
- dm_we=1, dm_wdata=0xA5A5A5A5.
- stall high 2 cycles.
- WB cycle: reg_we=0.
REQ-023 Timeout, TIMEOUT_CYC=4, no ack -> dm_req high exactly 4 cycles, then WB with result=0, reg_we=0, err=1 staying high; a following load with prompt ack completes normally.
REQ-024 Ack coincident with the final timeout cycle -> err stays 0 and WB delivers dm_rdata.
REQ-025 rst asserted during the 2nd ACCESS cycle -> dm_req falls before the next edge, state is IDLE, err=0; a stray dm_ack afterwards causes no reg_we.
